// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception controller
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_HANDLER,
    S_RETURN
  } exc_state_e;

  localparam logic [3:0]  CAUSE_NONE          = 4'd0;
  localparam logic [3:0]  CAUSE_OVF           = 4'd1;
  localparam logic [3:0]  CAUSE_UNDEF         = 4'd2;
  localparam logic [3:0]  CAUSE_IRQ_BASE      = 4'd8;
  localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'd112;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder for interrupt lines
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [2:0]         idx_o,
  output logic [NUM_IRQ-1:0] grant_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = 3'd0;
    grant_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o      = 3'(i);
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception/interrupt sequencer driving pipeline flush and PC redirect
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR  = DEFAULT_VECTOR_ADDR,
  parameter int          FLUSH_CYCLES = 3,
  parameter int          NUM_IRQ      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ovf_ex,
  input  logic [31:0]        ovf_pc,
  input  logic               undef_id,
  input  logic [31:0]        undef_pc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        irq_pc,
  input  logic               stall,
  input  logic               eret_id,
  output logic               exception_flush,
  output logic               exception_mux_control,
  output logic               pc_redirect_valid,
  output logic [31:0]        pc_redirect,
  output logic [31:0]        epc,
  output logic [3:0]         cause,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_handler,
  output logic               double_fault
);

  exc_state_e   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  epc_q, epc_d;
  logic [3:0]   cause_q, cause_d;
  logic         ie_q, ie_d;
  logic         dfault_q, dfault_d;

  logic               irq_valid;
  logic [2:0]         irq_idx;
  logic [NUM_IRQ-1:0] irq_grant;
  logic               take_irq;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_irq_prio_enc (
    .req_i   (irq),
    .valid_o (irq_valid),
    .idx_o   (irq_idx),
    .grant_o (irq_grant)
  );

  // Interrupts yield to synchronous faults and wait out hazard stalls.
  assign take_irq = (state_q == S_IDLE) && !ovf_ex && !undef_id &&
                    ie_q && !stall && irq_valid;
  assign irq_ack  = (take_irq && !rst) ? irq_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      epc_q    <= 32'd0;
      cause_q  <= CAUSE_NONE;
      ie_q     <= 1'b1;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      ie_q     <= ie_d;
      dfault_q <= dfault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    ie_d     = ie_q;
    dfault_d = dfault_q;
    case (state_q)
      S_IDLE: begin
        if (ovf_ex || undef_id || take_irq) begin
          state_d = S_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          ie_d    = 1'b0;
          if (ovf_ex) begin
            epc_d   = ovf_pc;
            cause_d = CAUSE_OVF;
          end else if (undef_id) begin
            epc_d   = undef_pc;
            cause_d = CAUSE_UNDEF;
          end else begin
            epc_d   = irq_pc;
            cause_d = CAUSE_IRQ_BASE | {1'b0, irq_idx};
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == 3'd0) state_d = S_REDIRECT;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_REDIRECT: state_d = S_HANDLER;
      S_HANDLER: begin
        if (ovf_ex || undef_id) dfault_d = 1'b1;
        if (eret_id && !stall)  state_d  = S_RETURN;
      end
      S_RETURN: begin
        state_d = S_IDLE;
        ie_d    = 1'b1;
        cause_d = CAUSE_NONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exception_flush       = 1'b0;
    exception_mux_control = 1'b0;
    pc_redirect_valid     = 1'b0;
    pc_redirect           = 32'd0;
    in_handler            = 1'b0;
    case (state_q)
      S_FLUSH: exception_flush = 1'b1;
      S_REDIRECT: begin
        exception_flush       = 1'b1;
        exception_mux_control = 1'b1;
        pc_redirect_valid     = 1'b1;
        pc_redirect           = VECTOR_ADDR;
      end
      S_HANDLER: in_handler = 1'b1;
      S_RETURN: begin
        exception_flush   = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = epc_q;
      end
      default: ;
    endcase
    epc          = epc_q;
    cause        = cause_q;
    double_fault = dfault_q;
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ovf_ex, undef_id, stall, eret_id;
  logic [31:0] ovf_pc, undef_pc, irq_pc;
  logic [3:0]  irq;
  logic        exception_flush, exception_mux_control, pc_redirect_valid;
  logic [31:0] pc_redirect, epc;
  logic [3:0]  cause, irq_ack;
  logic        in_handler, double_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exception_ctrl #(.VECTOR_ADDR(32'd112), .FLUSH_CYCLES(3), .NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .ovf_ex(ovf_ex), .ovf_pc(ovf_pc), .undef_id(undef_id),
    .undef_pc(undef_pc), .irq(irq), .irq_pc(irq_pc), .stall(stall), .eret_id(eret_id),
    .exception_flush(exception_flush), .exception_mux_control(exception_mux_control),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect), .epc(epc),
    .cause(cause), .irq_ack(irq_ack), .in_handler(in_handler), .double_fault(double_fault)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for HANDLER, then ERET back to IDLE.
  task automatic leave_handler();
    int k = 0;
    while (!in_handler && k < 20) begin step(); k++; end
    checks++;
    if (in_handler !== 1'b1) begin errors++; $display("FAIL reach_handler got=%b exp=1", in_handler); end
    eret_id = 1'b1; stall = 1'b0;
    step();
    eret_id = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ovf_ex = 0; undef_id = 0; stall = 0; eret_id = 0; irq = 4'b0;
    ovf_pc = 0; undef_pc = 0; irq_pc = 0;
    step(2);
    checks++;
    if ({exception_flush, exception_mux_control, pc_redirect_valid, in_handler, double_fault} !== 5'b0 ||
        pc_redirect !== 32'd0 || epc !== 32'd0 || cause !== 4'd0 || irq_ack !== 4'd0) begin
      errors++; $display("FAIL reset_outputs flush=%b epc=%h cause=%h exp all zero", exception_flush, epc, cause);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    ovf_ex = 1'b1; ovf_pc = 32'h40;
    #1;
    checks++;
    if (irq_ack !== 4'b0) begin errors++; $display("FAIL ovf_irq_ack got=%b exp=0000", irq_ack); end
    step();
    ovf_ex = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (exception_flush !== 1'b1 || pc_redirect_valid !== 1'b0 || exception_mux_control !== 1'b0) begin
        errors++; $display("FAIL ovf_flush_t%0d flush=%b valid=%b exp flush=1 valid=0", i, exception_flush, pc_redirect_valid);
      end
      step();
    end
    checks++;
    if (pc_redirect_valid !== 1'b1 || pc_redirect !== 32'd112 || exception_mux_control !== 1'b1 || exception_flush !== 1'b1) begin
      errors++; $display("FAIL ovf_redirect valid=%b pc=%0d mux=%b exp 1/112/1", pc_redirect_valid, pc_redirect, exception_mux_control);
    end
    step();
    checks++;
    if (in_handler !== 1'b1 || epc !== 32'h40 || cause !== 4'd1 || exception_flush !== 1'b0 || pc_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_handler in=%b epc=%h cause=%h exp 1/40/1", in_handler, epc, cause);
    end
  endtask

  task automatic test_return();
    eret_id = 1'b1; stall = 1'b1;
    step(2);
    checks++;
    if (in_handler !== 1'b1 || pc_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL eret_stalled in=%b valid=%b exp 1/0", in_handler, pc_redirect_valid);
    end
    stall = 1'b0;
    step();
    eret_id = 1'b0;
    checks++;
    if (exception_flush !== 1'b1 || pc_redirect_valid !== 1'b1 || pc_redirect !== 32'h40 ||
        exception_mux_control !== 1'b0 || in_handler !== 1'b0) begin
      errors++; $display("FAIL return_cycle flush=%b valid=%b pc=%h mux=%b exp 1/1/40/0", exception_flush, pc_redirect_valid, pc_redirect, exception_mux_control);
    end
    step();
    checks++;
    if (cause !== 4'd0 || epc !== 32'h40 || exception_flush !== 1'b0 || pc_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL return_idle cause=%h epc=%h flush=%b exp 0/40/0", cause, epc, exception_flush);
    end
  endtask

  task automatic test_priority();
    ovf_ex = 1'b1; undef_id = 1'b1; irq = 4'b0110;
    ovf_pc = 32'h80; undef_pc = 32'h7c; irq_pc = 32'h90;
    #1;
    checks++;
    if (irq_ack !== 4'b0) begin errors++; $display("FAIL prio_irq_ack got=%b exp=0000", irq_ack); end
    step();
    ovf_ex = 1'b0; undef_id = 1'b0;
    step(4);
    checks++;
    if (cause !== 4'd1 || epc !== 32'h80 || in_handler !== 1'b1 || irq_ack !== 4'b0) begin
      errors++; $display("FAIL prio_ovf cause=%h epc=%h ack=%b exp 1/80/0000", cause, epc, irq_ack);
    end
    leave_handler();
    checks++;
    if (irq_ack !== 4'b0010) begin errors++; $display("FAIL prio_irq1_ack got=%b exp=0010", irq_ack); end
    step();
    irq = 4'b0;
    checks++;
    if (cause !== 4'h9 || epc !== 32'h90 || exception_flush !== 1'b1) begin
      errors++; $display("FAIL prio_irq1_entry cause=%h epc=%h exp 9/90", cause, epc);
    end
    leave_handler();
  endtask

  task automatic test_stall_gating();
    irq = 4'b0001; stall = 1'b1; irq_pc = 32'hA0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (irq_ack !== 4'b0 || exception_flush !== 1'b0) begin
        errors++; $display("FAIL stall_block_%0d ack=%b flush=%b exp 0000/0", i, irq_ack, exception_flush);
      end
      step();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (irq_ack !== 4'b0001) begin errors++; $display("FAIL stall_release_ack got=%b exp=0001", irq_ack); end
    step();
    irq = 4'b0;
    checks++;
    if (exception_flush !== 1'b1 || epc !== 32'hA0 || cause !== 4'h8) begin
      errors++; $display("FAIL stall_entry flush=%b epc=%h cause=%h exp 1/a0/8", exception_flush, epc, cause);
    end
    leave_handler();
  endtask

  task automatic test_double_fault();
    undef_id = 1'b1; undef_pc = 32'h20;
    step();
    undef_id = 1'b0;
    step(4);
    undef_id = 1'b1; undef_pc = 32'h60;
    step();
    undef_id = 1'b0;
    checks++;
    if (double_fault !== 1'b1 || epc !== 32'h20 || cause !== 4'd2 || in_handler !== 1'b1) begin
      errors++; $display("FAIL dfault_set df=%b epc=%h cause=%h exp 1/20/2", double_fault, epc, cause);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pc_redirect_valid !== 1'b0 || exception_flush !== 1'b0 || double_fault !== 1'b1) begin
        errors++; $display("FAIL dfault_hold_%0d valid=%b df=%b exp 0/1", i, pc_redirect_valid, double_fault);
      end
      step();
    end
    leave_handler();
    eret_id = 1'b1;
    step();
    eret_id = 1'b0;
    checks++;
    if (exception_flush !== 1'b0 || pc_redirect_valid !== 1'b0 || double_fault !== 1'b1) begin
      errors++; $display("FAIL eret_in_idle flush=%b valid=%b df=%b exp 0/0/1", exception_flush, pc_redirect_valid, double_fault);
    end
  endtask

  task automatic test_reset_mid_flush();
    ovf_ex = 1'b1; ovf_pc = 32'hC0;
    step();
    ovf_ex = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (exception_flush !== 1'b0 || epc !== 32'd0 || cause !== 4'd0 || double_fault !== 1'b0 || pc_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset flush=%b epc=%h cause=%h df=%b exp all zero", exception_flush, epc, cause, double_fault);
    end
    step();
    rst = 1'b0;
    irq = 4'b0100; irq_pc = 32'hE0;
    #1;
    checks++;
    if (irq_ack !== 4'b0100) begin errors++; $display("FAIL post_reset_ack got=%b exp=0100", irq_ack); end
    step();
    irq = 4'b0;
    checks++;
    if (cause !== 4'hA || epc !== 32'hE0 || exception_flush !== 1'b1) begin
      errors++; $display("FAIL post_reset_entry cause=%h epc=%h exp a/e0", cause, epc);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_return();
    test_priority();
    test_stall_gating();
    test_double_fault();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Sequences the pipeline on exceptions and interrupts.
- Collects EX-stage overflow, ID-stage undefined opcode and external interrupt requests, then decides which one is taken.
- For the taken event it captures EPC and cause, drives a multi-cycle exception_flush into the IF/ID/EX registers, and redirects the PC to the handler vector.
- Sits beside the IF/ID hazard logic and owns the exception_flush / exception_mux_control signals feeding the PC and IF_ID register.

Parameters:
- VECTOR_ADDR, 32'd112, handler entry address (word 28).
- FLUSH_CYCLES, 3, cycles exception_flush is held on entry; legal range 1..7.
- NUM_IRQ, 4, external interrupt lines; legal range 1..8.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ovf_ex  in  1  ALU overflow for the instruction in EX.
- ovf_pc  in  32  PC of the instruction in EX.
- undef_id  in  1  undefined opcode decoded in ID.
- undef_pc  in  32  PC of the instruction in ID (IF_ID[63:32]-4).
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_pc  in  32  PC of the oldest unretired instruction, used as the resume point.
- stall  in  1  hazard-detector stall (PC_write asserted).
- eret_id  in  1  return-from-exception decoded in ID.
- exception_flush  out  1  clears IF_ID and the ID_EX control bits.
- exception_mux_control  out  1  selects VECTOR_ADDR at the PC mux.
- pc_redirect_valid  out  1  one-cycle PC load strobe.
- pc_redirect  out  32  PC load value.
- epc  out  32  saved return address.
- cause  out  4  0=none, 1=overflow, 2=undefined, {1'b1, idx[2:0]}=irq.
- irq_ack  out  NUM_IRQ  one-hot pulse for the accepted irq.
- in_handler  out  1  high in HANDLER state.
- double_fault  out  1  sticky flag.

Behaviour:
- Reset (async, any state): state=IDLE; every output, epc, cause and the counter are 0; ie=1.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN. All outputs are Moore outputs (registered state), except irq_ack.
- IDLE, event priority at each posedge:
  - ovf_ex > undef_id > irq.
  - irq is taken only if ie=1 and stall=0; among irq lines the lowest index wins.
- IDLE, on a taken event:
  - Latch epc: ovf_pc, undef_pc or irq_pc respectively.
  - Latch cause.
  - Clear ie, load counter=FLUSH_CYCLES-1, go to FLUSH.
  - irq_ack pulses high in the same cycle the irq is sampled (combinational from the accept decision).
- stall does not block ovf_ex or undef_id.
- FLUSH: exception_flush=1. If counter==0 go to REDIRECT, else decrement. Net effect: flush is high for exactly FLUSH_CYCLES cycles.
- REDIRECT, 1 cycle: exception_flush=1, exception_mux_control=1, pc_redirect_valid=1, pc_redirect=VECTOR_ADDR. Then go to HANDLER.
- HANDLER: in_handler=1.
  - irq is ignored (left pending, since it is level-sensitive).
  - ovf_ex or undef_id sets double_fault. epc, cause and state are unchanged.
  - eret_id && !stall: go to RETURN.
- RETURN, 1 cycle: exception_flush=1, pc_redirect_valid=1, pc_redirect=epc, exception_mux_control=0. Then set ie=1, clear cause to 0, go to IDLE.
- epc holds its value until the next taken event.
- Simultaneous ovf_ex and irq: overflow is taken, irq_ack stays 0, and the irq remains pending.
- eret_id seen in IDLE: ignored.
- double_fault is cleared only by rst.
- Entry latency: event sampled at edge t → flush high during cycles t+1..t+FLUSH_CYCLES → redirect strobe in cycle t+FLUSH_CYCLES+1.

Decomposition:
- Shared package exc_pkg holds:
  - state enum;
  - cause constants CAUSE_NONE=0, CAUSE_OVF=1, CAUSE_UNDEF=2, CAUSE_IRQ_BASE=8;
  - default VECTOR_ADDR.
- One natural sub-module: irq_prio_enc, a NUM_IRQ-wide lowest-index priority encoder producing valid, idx[2:0] and the one-hot grant.

Test Plan (defaults: FLUSH_CYCLES=3, VECTOR_ADDR=112):
- Reset: rst=1 mid-FLUSH → all outputs 0 in the same cycle; after release, state=IDLE and an irq is accepted.
- Overflow: ovf_ex=1, ovf_pc=0x40 at edge t → flush=1 for t+1..t+3; t+4 shows redirect_valid=1, pc_redirect=112, mux_control=1; epc=0x40, cause=1, in_handler=1 from t+5.
- Priority: ovf_ex=1, undef_id=1 and irq=4'b0110 together → cause=1, irq_ack=0. After ERET, irq line 1 is taken with cause=4'h9, irq_ack=4'b0010.
- Stall gating: irq=1 with stall=1 for 5 cycles → no entry. stall drops → entry next edge, epc=irq_pc.
- Return: in HANDLER, eret_id=1 with stall=1 → stays in HANDLER. stall=0 → RETURN cycle has flush=1, redirect_valid=1, pc_redirect=epc=0x40; then IDLE with cause=0.
- Double fault: undef_id=1 in HANDLER → double_fault=1 stays set, epc and cause unchanged, no new redirect.
